alu_regfile: RTL and testbench

- Register file sitting directly upstream of the ALU in the single-cycle datapath.
- Two combinational read ports drive the ALU A and B operands; one synchronous write port takes the write-back value (ALU Result or other).
- A status register captures the ALU flags (Zero, Carryout, Overflow, Set) for later branch and condition use.
- A sticky overflow indicator, with optional write suppression on overflow, supports trapping arithmetic.

---
 rtl/alu_regfile.sv | 94 +++++++++
 tb/tb_alu_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile.sv
// Register file feeding the ALU operands: two combinational read ports with
// write-through bypass, one write port, ALU flag register and sticky overflow.
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              flag_we,
    input  logic              alu_zero,
    input  logic              alu_carryout,
    input  logic              alu_overflow,
    input  logic              alu_set,
    input  logic              ovf_block,
    input  logic              ovf_clr,
    output logic [3:0]        flags,
    output logic              ovf_sticky
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [3:0]        flags_q, flags_d;
    logic              ovf_sticky_q, ovf_sticky_d;
    logic              wr_ok;

    // A write that overflows under ovf_block neither commits nor bypasses.
    assign wr_ok = we && (wa != '0) && !(ovf_block && alu_overflow);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wa] = wd;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d = {alu_overflow, alu_carryout, alu_zero, alu_set};
        end
    end

    // Set dominates clear when both occur in the same cycle.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (flag_we && alu_overflow) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            flags_q      <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            flags_q      <= flags_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    // Reads are masked during reset so a pending bypass cannot leak wd.
    always_comb begin
        rd1 = '0;
        if (rst_n && (ra1 != '0)) begin
            rd1 = (wr_ok && (wa == ra1)) ? wd : regs_q[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rst_n && (ra2 != '0)) begin
            rd2 = (wr_ok && (wa == ra2)) ? wd : regs_q[ra2];
        end
    end

    assign flags      = flags_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_regfile.sv
// Directed-vector bench for alu_regfile with hand-computed expectations.
module tb_alu_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    logic        we, flag_we;
    logic        alu_zero, alu_carryout, alu_overflow, alu_set;
    logic        ovf_block, ovf_clr;
    logic [3:0]  flags;
    logic        ovf_sticky;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ra1          (ra1),
        .ra2          (ra2),
        .rd1          (rd1),
        .rd2          (rd2),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .flag_we      (flag_we),
        .alu_zero     (alu_zero),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .alu_set      (alu_set),
        .ovf_block    (ovf_block),
        .ovf_clr      (ovf_clr),
        .flags        (flags),
        .ovf_sticky   (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0;
        flag_we = 1'b0; alu_zero = 1'b0; alu_carryout = 1'b0;
        alu_overflow = 1'b0; alu_set = 1'b0;
        ovf_block = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ra1 = 5'd5; ra2 = 5'd31;
        idle();
        // bypass candidate present during reset must not reach the read port
        we = 1'b1; wa = 5'd5; wd = 32'hdeadbeef;
        #3;
        chk("rst_rd1_bypass_masked", rd1, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_sticky", {31'h0, ovf_sticky}, 32'h0);
        step();

        // write r3 with same-cycle bypass
        we = 1'b1; wa = 5'd3; wd = 32'haaaaaaaa; ra1 = 5'd3; ra2 = 5'd4;
        #1;
        chk("byp_rd1", rd1, 32'haaaaaaaa);
        chk("byp_rd2_other", rd2, 32'h0);
        step();
        idle(); ra2 = 5'd3;
        #1;
        chk("stored_rd2", rd2, 32'haaaaaaaa);
        chk("stored_rd1", rd1, 32'haaaaaaaa);
        step();

        // r0 protection
        we = 1'b1; wa = 5'd0; wd = 32'hffffffff; ra1 = 5'd0;
        #1;
        chk("r0_same_cycle", rd1, 32'h0);
        step();
        idle();
        #1;
        chk("r0_next_cycle", rd1, 32'h0);

        // preload r7
        we = 1'b1; wa = 5'd7; wd = 32'h1fffffff;
        step();
        // overflowing write, blocked
        we = 1'b1; wa = 5'd7; wd = 32'h7fffffff; alu_overflow = 1'b1;
        ovf_block = 1'b1; flag_we = 1'b1; ra1 = 5'd7;
        #1;
        chk("ovf_block_no_bypass", rd1, 32'h1fffffff);
        step();
        idle();
        #1;
        chk("ovf_block_no_commit", rd1, 32'h1fffffff);
        chk("ovf_flags", {28'h0, flags}, 32'h8);
        chk("ovf_sticky_set", {31'h0, ovf_sticky}, 32'h1);

        // overflow without block still writes; flags untouched without flag_we
        we = 1'b1; wa = 5'd8; wd = 32'h12345678; alu_overflow = 1'b1; ra2 = 5'd8;
        #1;
        chk("ovf_unblocked_bypass", rd2, 32'h12345678);
        step();
        idle();
        #1;
        chk("ovf_unblocked_commit", rd2, 32'h12345678);
        chk("flags_hold_no_we", {28'h0, flags}, 32'h8);

        // SLTU equal operands: zero only
        flag_we = 1'b1; alu_zero = 1'b1;
        step();
        idle();
        #1;
        chk("flags_zero", {28'h0, flags}, 32'h2);
        chk("sticky_holds", {31'h0, ovf_sticky}, 32'h1);
        alu_set = 1'b1; alu_carryout = 1'b1; alu_overflow = 1'b1;
        step();
        step();
        idle();
        chk("flags_hold_2cyc", {28'h0, flags}, 32'h2);
        chk("sticky_no_flag_we", {31'h0, ovf_sticky}, 32'h1);

        // set beats clear
        ovf_clr = 1'b1; flag_we = 1'b1; alu_overflow = 1'b1;
        step();
        idle();
        #1;
        chk("sticky_set_wins", {31'h0, ovf_sticky}, 32'h1);
        chk("flags_ovf_only", {28'h0, flags}, 32'h8);
        ovf_clr = 1'b1;
        step();
        idle();
        chk("sticky_cleared", {31'h0, ovf_sticky}, 32'h0);
        step();
        chk("sticky_stays_clear", {31'h0, ovf_sticky}, 32'h0);

        // re-arm sticky, and dual-port bypass to the same address
        flag_we = 1'b1; alu_overflow = 1'b1; alu_carryout = 1'b1;
        we = 1'b1; wa = 5'd9; wd = 32'hcafef00d; ra1 = 5'd9; ra2 = 5'd9;
        #1;
        chk("dual_byp_rd1", rd1, 32'hcafef00d);
        chk("dual_byp_rd2", rd2, 32'hcafef00d);
        step();
        idle();
        chk("flags_ovf_carry", {28'h0, flags}, 32'hc);
        chk("sticky_rearmed", {31'h0, ovf_sticky}, 32'h1);

        // asynchronous reset mid-cycle
        ra1 = 5'd3; ra2 = 5'd7;
        #2;
        chk("pre_async_rd1", rd1, 32'haaaaaaaa);
        rst_n = 1'b0;
        #1;
        chk("async_rd1", rd1, 32'h0);
        chk("async_rd2", rd2, 32'h0);
        chk("async_flags", {28'h0, flags}, 32'h0);
        chk("async_sticky", {31'h0, ovf_sticky}, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_r3", rd1, 32'h0);
        ra1 = 5'd9;
        #1;
        chk("post_rst_r9", rd1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
